spi_cfg_controller: RTL
=======================

Name: spi_cfg_controller

Overview:
- Two-requester SPI write controller that configures the on-chip register-file peripheral (addresses 0x00–0x04) over cs_n/sclk/copi.
- Round-robin arbitration between requesters; each granted request is serialised as one 16-bit write frame.
- Sits between the configuration sources (e.g. a debug port and a sequencer) and the SPI register peripheral, in the same clk domain as the peripheral's synchroniser.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 3..255 (≥3 so copi settles through the peripheral's 2-FF synchroniser before each sclk rise).
- CS_GAP, 2, minimum clk cycles cs_n stays high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 handshake accepted this cycle.
- req0_addr  in  7  requester 0 target register address.
- req0_data  in  8  requester 0 write data.
- req1_valid / req1_ready / req1_addr / req1_data  in/out/in/in  1/1/7/8  same as requester 0, for requester 1.
- busy  out  1  a frame is in progress (not IDLE).
- grant_id  out  1  requester owning the current or most recent frame.
- done  out  1  one-cycle pulse when a frame completes (cs_n rises).
- sclk  out  1  SPI clock, mode 0, idles low.
- cs_n  out  1  active-low chip select.
- copi  out  1  serial data to the peripheral, MSB first.

Behaviour:
- Reset values: sclk=0, cs_n=1, copi=0, req*_ready=0, busy=0, done=0, grant_id=0, state=IDLE, last_grant=1 so requester 0 wins first.
- Frame format: bit15=1 (write), bits14:8=addr, bits7:0=data; shifted MSB first.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: if any valid, ready is asserted combinationally for exactly one requester, chosen round-robin (priority to the requester not in last_grant).
  - On valid&ready (cycle N): latch the frame, set grant_id and last_grant, go to SETUP.
  - Ready is never asserted outside IDLE.
  - Inputs may change freely once the handshake completes.
- SETUP (from N+1): cs_n=0, copi=frame[15], sclk=0 for CLK_DIV cycles.
- SHIFT: sclk toggles every CLK_DIV cycles.
  - Rising edge k (k=0..15) occurs at cycle N+1+(2k+1)·CLK_DIV.
  - On each falling edge, copi advances to the next bit.
  - After the 16th rising edge, sclk falls at N+1+32·CLK_DIV; copi holds bit0.
- HOLD: cs_n stays low for CLK_DIV more cycles; cs_n rises at N+1+33·CLK_DIV; done=1 that cycle; copi returns to 0.
- GAP: cs_n high for CS_GAP cycles, then IDLE; earliest next handshake is at N+1+33·CLK_DIV+CS_GAP.
- Exactly 16 rising sclk edges per frame; never a partial frame except on reset.
- Addresses >4 are transmitted unchanged (the peripheral ignores them); no error is flagged.
- Simultaneous valids: strict alternation 0,1,0,1…
- A requester that drops valid before ready is not granted; it cannot be starved beyond one frame.
- Asynchronous reset mid-frame: outputs go immediately to reset values (cs_n=1, sclk=0); the frame is aborted and last_grant is reset.
- Internal divider counter is 8 bits; bit counter is 4 bits, wrapping 15→0 only at the end of SHIFT.

Decomposition:
- Shared package spi_cfg_pkg:
  - FRAME_W=16, WRITE_BIT=15.
  - Register address constants REG_EN_OUT_LO=0, REG_EN_OUT_HI=1, REG_EN_PWM_LO=2, REG_EN_PWM_HI=3, REG_DUTY=4.
  - State enum (IDLE, SETUP, SHIFT, HOLD, GAP).
- One sub-module: spi_clk_div.
  - CLK_DIV counter producing one-cycle rise/fall strobes and sclk level.
  - Enabled only during SETUP/SHIFT; cleared on entry to SETUP.

Test Plan (CLK_DIV=4, CS_GAP=2):
- Single write, req0 addr=0x04 data=0xA5 handshake at N → cs_n low N+1..N+132; 16 sclk rises at N+5, N+13, …, N+125; copi bits 1,0000100,10100101; done at N+133; the peripheral model's reg_4 becomes 0xA5.
- Both valid continuously, req0 (0x02,0x11) and req1 (0x03,0x22) → grants 0,1,0,1; second handshake at N+135; grant_id follows; no overlap of cs_n low windows.
- req1 only valid after reset → req1 granted immediately; following simultaneous request goes to req0.
- Back-to-back req0 writes to addr 0x00 with data 0xFF then 0x00 → cs_n high exactly 2 cycles between frames; reg_0 ends at 0x00.
- Assert rst_n low at N+60 mid-frame → same cycle cs_n=1, sclk=0, busy=0, no done; after release, a new write completes normally.
- Address 0x7F, data 0x5A → full 16-edge frame sent, done pulses, peripheral registers 0–4 unchanged.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration write controller.
//   FRAME_W / WRITE_BIT : frame geometry (bit15 = write flag, 14:8 addr, 7:0 data)
//   REG_*               : register-file peripheral addresses 0x00..0x04
//   state_t             : controller frame sequencing states
//   make_frame()        : assemble a write frame from address and data
package spi_cfg_pkg;

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned WRITE_BIT = 15;

  localparam logic [6:0] REG_EN_OUT_LO = 7'h00;
  localparam logic [6:0] REG_EN_OUT_HI = 7'h01;
  localparam logic [6:0] REG_EN_PWM_LO = 7'h02;
  localparam logic [6:0] REG_EN_PWM_HI = 7'h03;
  localparam logic [6:0] REG_DUTY      = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [6:0] addr,
                                                    input logic [7:0] data);
    logic [FRAME_W-1:0] f;
    f            = {1'b0, addr, data};
    f[WRITE_BIT] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/spi_cfg_controller_if.sv
// Requester-side handshake bundle for the SPI configuration controller.
//   reqN_valid : requester N has a write pending
//   reqN_ready : controller accepts requester N this cycle
//   reqN_addr  : 7-bit target register address
//   reqN_data  : 8-bit write data
// master : configuration source side; slave : controller side.
interface spi_cfg_controller_if;

  logic       req0_valid;
  logic       req0_ready;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/spi_clk_div.sv
// SPI clock divider: toggles sclk every CLK_DIV enabled clk cycles.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : count enable (controller in SETUP or SHIFT)
//   clr        : restart the half-period count with sclk low
//   sclk       : registered SPI clock level
//   rise, fall : one-cycle strobes in the cycle before sclk rises / falls
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       tick;

  assign tick = en && !clr && (cnt_q == DIV_MAX);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign rise = tick && !sclk_q;
  assign fall = tick && sclk_q;

endmodule

// File: rtl/spi_cfg_controller.sv
// Two-requester SPI (mode 0) write controller for the register-file peripheral.
// Round-robin arbitration; each grant is sent as one 16-bit MSB-first frame.
//   clk, rst_n : system clock, asynchronous active-low reset
//   req        : requester handshake bundle (slave side)
//   busy       : frame in progress
//   grant_id   : requester owning the current / most recent frame
//   done       : one-cycle pulse in the cycle cs_n rises
//   sclk, cs_n, copi : SPI bus
module spi_cfg_controller
  import spi_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_cfg_controller_if.slave  req,
  output logic                 busy,
  output logic                 grant_id,
  output logic                 done,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 copi
);

  localparam logic [7:0] HOLD_MAX = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_MAX  = 8'(CS_GAP - 1);

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic                 cs_n_q, cs_n_d;
  logic                 copi_q, copi_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 grant_id_q, grant_id_d;
  logic                 last_grant_q, last_grant_d;

  logic                 any_valid, pick, hs;
  logic                 div_en, div_rise, div_fall;

  // With both requesters pending, the one not served last wins.
  assign any_valid = req.req0_valid || req.req1_valid;
  assign pick      = (req.req0_valid && req.req1_valid) ? ~last_grant_q : req.req1_valid;
  assign hs        = (state_q == IDLE) && any_valid;

  assign req.req0_ready = hs && !pick;
  assign req.req1_ready = hs && pick;

  assign div_en = (state_q == SETUP) || (state_q == SHIFT);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (hs),
    .sclk  (sclk),
    .rise  (div_rise),
    .fall  (div_fall)
  );

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    bit_cnt_d    = bit_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    cs_n_d       = cs_n_q;
    copi_d       = copi_q;
    done_d       = 1'b0;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          frame_d      = pick ? make_frame(req.req1_addr, req.req1_data)
                              : make_frame(req.req0_addr, req.req0_data);
          grant_id_d   = pick;
          last_grant_d = pick;
          bit_cnt_d    = '0;
          cs_n_d       = 1'b0;
          copi_d       = frame_d[FRAME_W-1];
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (div_rise) state_d = SHIFT;
      end
      SHIFT: begin
        // frame_q is shifted left each falling edge so bit 14 is always next.
        if (div_fall) begin
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            copi_d    = frame_q[FRAME_W-2];
            frame_d   = frame_q << 1;
          end
        end
      end
      HOLD: begin
        if (wait_cnt_q == HOLD_MAX) begin
          wait_cnt_d = '0;
          cs_n_d     = 1'b1;
          copi_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (wait_cnt_q == GAP_MAX) begin
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      cs_n_q       <= 1'b1;
      copi_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      bit_cnt_q    <= bit_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      cs_n_q       <= cs_n_d;
      copi_q       <= copi_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cs_n     = cs_n_q;
  assign copi     = copi_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule
